// File: rtl/sj_driver_pkg.sv
// Shared types and constants for the Synthesijer method driver.
package sj_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_RUN,
    ST_DONE
  } drv_state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_TIMEOUT = 10000;

  localparam logic [31:0] RUN_CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sj_method_driver_if.sv
// Preload stream, target memory port and method handshake of the driver.
interface sj_method_driver_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_we;
  logic              mem_oe;
  logic [DATA_W-1:0] mem_din;
  logic              method_req;
  logic              method_busy;
  logic              method_return;

  modport master (
    input  ld_valid, ld_data, method_busy, method_return,
    output ld_ready, mem_address, mem_we, mem_oe, mem_din, method_req
  );

  modport slave (
    output ld_valid, ld_data, method_busy, method_return,
    input  ld_ready, mem_address, mem_we, mem_oe, mem_din, method_req
  );
endinterface

// File: rtl/sj_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and enable.
module sj_sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v >= MAX) ? MAX : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/sj_method_driver.sv
// Preloads a Synthesijer target memory from a stream, then runs one method
// call and captures its return value, busy duration and timeout status.
module sj_method_driver
  import sj_driver_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  load_len,
  sj_method_driver_if.master bus,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [31:0]       run_cycles
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  drv_state_t        state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic              ld_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              method_req_q;
  logic [TO_W-1:0]   tcnt;

  logic active;
  logic expire;
  logic beat;
  logic start_ok;

  assign active   = (state == ST_KICK) || (state == ST_RUN);
  // Timeout is checked before busy so an expiry always wins a tie.
  assign expire   = active && (tcnt == TO_W'(TIMEOUT - 1));
  assign beat     = (state == ST_LOAD) && bus.ld_valid && ld_ready_q;
  assign start_ok = (state == ST_IDLE) && start;

  assign bus.ld_ready    = ld_ready_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_oe      = 1'b1;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.method_req  = method_req_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      ld_ready_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_din_q     <= '0;
      method_req_q  <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timed_out     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            len_q     <= load_len;
            idx_q     <= '0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            if (load_len == '0) begin
              method_req_q <= 1'b1;
              state        <= ST_KICK;
            end else begin
              ld_ready_q <= 1'b1;
              state      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            mem_we_q      <= 1'b1;
            mem_din_q     <= bus.ld_data;
            mem_address_q <= base_q + ADDR_W'(idx_q);
            idx_q         <= idx_q + LEN_W'(1);
            if (idx_q == len_q - LEN_W'(1)) begin
              ld_ready_q   <= 1'b0;
              method_req_q <= 1'b1;
              state        <= ST_KICK;
            end
          end
        end
        ST_KICK: begin
          if (expire) begin
            method_req_q <= 1'b0;
            timed_out    <= 1'b1;
            pass         <= 1'b0;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else if (bus.method_busy) begin
            method_req_q <= 1'b0;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (expire) begin
            timed_out <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else if (!bus.method_busy) begin
            pass  <= bus.method_return;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Busy cycles are counted from the first sampled busy, including the KICK cycle.
  sj_sat_counter #(
    .WIDTH(32),
    .MAX  (RUN_CYCLES_MAX)
  ) u_run_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (start_ok),
    .en   (active && bus.method_busy),
    .count(run_cycles)
  );

  sj_sat_counter #(
    .WIDTH(TO_W),
    .MAX  (TO_W'(TIMEOUT))
  ) u_to_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (!active),
    .en   (active),
    .count(tcnt)
  );

endmodule
